control_sequencer: RTL and testbench

//  Hardwired control unit that replaces hand-driven T-state stimulus for the System datapath.

---
 rtl/ctrl_seq_pkg.sv | 97 +++++++++
 rtl/ctrl_seq_decode.sv | 44 ++++
 rtl/control_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_seq_pkg
//  Brief    : Shared opcode values, opcode classes, FSM step encoding and
//             control-bus bit positions for the hardwired control sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package ctrl_seq_pkg;

    // Opcode values carried in IR[31:27]
    localparam int OP_LD   = 0;
    localparam int OP_LDI  = 1;
    localparam int OP_ST   = 2;
    localparam int OP_ADD  = 3;
    localparam int OP_SUB  = 4;
    localparam int OP_AND  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_ORI  = 10;
    localparam int OP_ANDI = 11;
    localparam int OP_ADDI = 12;
    localparam int OP_MUL  = 15;
    localparam int OP_DIV  = 16;
    localparam int OP_BR   = 19;
    localparam int OP_IN   = 22;
    localparam int OP_OUT  = 23;
    localparam int OP_MFHI = 24;
    localparam int OP_MFLO = 25;
    localparam int OP_NOP  = 26;
    localparam int OP_HALT = 27;

    // drive_o bit positions (one-hot bus driver select)
    localparam int DRV_HI     = 0;
    localparam int DRV_LO     = 1;
    localparam int DRV_ZHI    = 2;
    localparam int DRV_ZLO    = 3;
    localparam int DRV_PC     = 4;
    localparam int DRV_MDR    = 5;
    localparam int DRV_C      = 6;
    localparam int DRV_INPORT = 7;

    // load_o bit positions
    localparam int LOAD_MAR     = 0;
    localparam int LOAD_Z       = 1;
    localparam int LOAD_PC      = 2;
    localparam int LOAD_MDR     = 3;
    localparam int LOAD_IR      = 4;
    localparam int LOAD_Y       = 5;
    localparam int LOAD_HI      = 6;
    localparam int LOAD_LO      = 7;
    localparam int LOAD_OUTPORT = 8;

    // reg_ctl_o bit positions
    localparam int REG_GRA   = 0;
    localparam int REG_GRB   = 1;
    localparam int REG_GRC   = 2;
    localparam int REG_RIN   = 3;
    localparam int REG_ROUT  = 4;
    localparam int REG_BAOUT = 5;

    // mem_o bit positions
    localparam int MEM_READ  = 0;
    localparam int MEM_WRITE = 1;
    localparam int MEM_EN    = 2;

    // Opcode classes; each class has its own execute sequence
    typedef enum logic [3:0] {
        CL_NOP    = 4'd0,
        CL_MFHI   = 4'd1,
        CL_MFLO   = 4'd2,
        CL_ALU_R  = 4'd3,
        CL_ALU_I  = 4'd4,
        CL_MULDIV = 4'd5,
        CL_LD     = 4'd6,
        CL_LDI    = 4'd7,
        CL_ST     = 4'd8,
        CL_BR     = 4'd9,
        CL_IN     = 4'd10,
        CL_OUT    = 4'd11,
        CL_HALT   = 4'd12
    } op_class_e;

    // Sequencer states; S_IDLE is the quiet T0 taken while run=0
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } step_e;

endpackage : ctrl_seq_pkg
`default_nettype wire

// File: rtl/ctrl_seq_decode.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_seq_decode
//  Brief    : Combinational opcode -> opcode-class decoder. Opcodes without
//             a defined execute sequence decode as NOP.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_seq_decode
    import ctrl_seq_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] opcode,
    output op_class_e        op_class
);

    // Map each opcode value onto the execute sequence it uses
    always_comb begin
        op_class = CL_NOP;
        case (opcode)
            OPC_W'(OP_LD):   op_class = CL_LD;
            OPC_W'(OP_LDI):  op_class = CL_LDI;
            OPC_W'(OP_ST):   op_class = CL_ST;
            OPC_W'(OP_ADD),
            OPC_W'(OP_SUB),
            OPC_W'(OP_AND),
            OPC_W'(OP_OR):   op_class = CL_ALU_R;
            OPC_W'(OP_ADDI),
            OPC_W'(OP_ANDI),
            OPC_W'(OP_ORI):  op_class = CL_ALU_I;
            OPC_W'(OP_MUL),
            OPC_W'(OP_DIV):  op_class = CL_MULDIV;
            OPC_W'(OP_BR):   op_class = CL_BR;
            OPC_W'(OP_IN):   op_class = CL_IN;
            OPC_W'(OP_OUT):  op_class = CL_OUT;
            OPC_W'(OP_MFHI): op_class = CL_MFHI;
            OPC_W'(OP_MFLO): op_class = CL_MFLO;
            OPC_W'(OP_HALT): op_class = CL_HALT;
            default:         op_class = CL_NOP;
        endcase
    end

endmodule : ctrl_seq_decode
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : control_sequencer
//  Brief    : Hardwired T-state control unit. Fetch in T0-T2, then a
//             per-opcode-class execute sequence in T3-T7. All outputs are a
//             decode of registered state only.
//  Config   : CTRL_SEQ_MEMWAIT_EN - when defined, T1, LD-T6 and ST-T7 wait
//             for mem_ready=1; otherwise mem_ready is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module control_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int OPC_W      = 5,
    parameter int MULDIV_CYC = 32,
    parameter int CNT_W      = 6     // 2**CNT_W must exceed MULDIV_CYC
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             run,
    input  logic [OPC_W-1:0] ir_opcode,
    input  logic             con_ff_bit,
    input  logic             mem_ready,
    output logic [7:0]       drive_o,
    output logic [8:0]       load_o,
    output logic [5:0]       reg_ctl_o,
    output logic [OPC_W-1:0] alu_op_o,
    output logic             incpc_o,
    output logic [2:0]       mem_o,
    output logic             halted_o,
    output logic [2:0]       step_o
);

    localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_CYC - 1);
    localparam logic [OPC_W-1:0] ALU_ADD     = OPC_W'(OP_ADD);

    step_e            state, state_n;
    op_class_e        op_class_q, op_class_n, dec_class;
    logic [OPC_W-1:0] opcode_q, opcode_n;
    logic [CNT_W-1:0] stall_cnt, stall_cnt_n;
    logic             mem_done;

`ifdef CTRL_SEQ_MEMWAIT_EN
    assign mem_done = mem_ready;
`else
    // Memory steps always complete in one cycle; mem_ready is kept for pinout only
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done         = 1'b1;
`endif

    ctrl_seq_decode #(
        .OPC_W    (OPC_W)
    ) u_decode (
        .opcode   (ir_opcode),
        .op_class (dec_class)
    );

    // State, latched opcode/class and stall counter registers
    always_ff @(posedge Clock) begin
        if (clear) begin
            state      <= S_IDLE;
            op_class_q <= CL_NOP;
            opcode_q   <= '0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_n;
            op_class_q <= op_class_n;
            opcode_q   <= opcode_n;
            stall_cnt  <= stall_cnt_n;
        end
    end

    // Next-state logic; the opcode is captured leaving T2 so execute-step
    // outputs depend only on registers
    always_comb begin
        state_n     = state;
        op_class_n  = op_class_q;
        opcode_n    = opcode_q;
        stall_cnt_n = stall_cnt;
        case (state)
            S_IDLE: if (run) state_n = S_T0;
            S_T0:   state_n = S_T1;
            S_T1:   if (mem_done) state_n = S_T2;
            S_T2: begin
                state_n    = S_T3;
                op_class_n = dec_class;
                opcode_n   = ir_opcode;
            end
            S_T3: begin
                case (op_class_q)
                    CL_ALU_R, CL_ALU_I, CL_LD, CL_LDI, CL_ST: begin
                        state_n     = S_T4;
                        stall_cnt_n = '0;
                    end
                    CL_MULDIV: begin
                        state_n     = S_T4;
                        stall_cnt_n = MULDIV_LOAD;
                    end
                    CL_BR: begin
                        state_n     = con_ff_bit ? S_T4 : S_IDLE;
                        stall_cnt_n = '0;
                    end
                    CL_HALT: state_n = S_HALT;
                    default: state_n = S_IDLE;
                endcase
            end
            S_T4: begin
                if (stall_cnt == '0) state_n = S_T5;
                else                 stall_cnt_n = stall_cnt - 1'b1;
            end
            S_T5: begin
                case (op_class_q)
                    CL_MULDIV, CL_LD, CL_ST, CL_BR: state_n = S_T6;
                    default:                        state_n = S_IDLE;
                endcase
            end
            S_T6: begin
                case (op_class_q)
                    CL_LD:   if (mem_done) state_n = S_T7;
                    CL_ST:   state_n = S_T7;
                    default: state_n = S_IDLE;
                endcase
            end
            S_T7: begin
                if (op_class_q == CL_ST) begin
                    if (mem_done) state_n = S_IDLE;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
    end

    // Output decode from state, latched class and latched opcode
    always_comb begin
        drive_o   = '0;
        load_o    = '0;
        reg_ctl_o = '0;
        alu_op_o  = '0;
        incpc_o   = 1'b0;
        mem_o     = '0;
        halted_o  = 1'b0;
        step_o    = 3'd0;
        case (state)
            S_T0: begin
                step_o            = 3'd0;
                drive_o[DRV_PC]   = 1'b1;
                incpc_o           = 1'b1;
                load_o[LOAD_MAR]  = 1'b1;
                load_o[LOAD_Z]    = 1'b1;
                alu_op_o          = ALU_ADD;
            end
            S_T1: begin
                step_o            = 3'd1;
                drive_o[DRV_ZLO]  = 1'b1;
                load_o[LOAD_PC]   = 1'b1;
                load_o[LOAD_MDR]  = 1'b1;
                mem_o[MEM_READ]   = 1'b1;
                mem_o[MEM_EN]     = 1'b1;
            end
            S_T2: begin
                step_o            = 3'd2;
                drive_o[DRV_MDR]  = 1'b1;
                load_o[LOAD_IR]   = 1'b1;
            end
            S_T3: begin
                step_o = 3'd3;
                case (op_class_q)
                    CL_MFHI: begin
                        drive_o[DRV_HI]    = 1'b1;
                        reg_ctl_o[REG_GRA] = 1'b1;
                        reg_ctl_o[REG_RIN] = 1'b1;
                    end
                    CL_MFLO: begin
                        drive_o[DRV_LO]    = 1'b1;
                        reg_ctl_o[REG_GRA] = 1'b1;
                        reg_ctl_o[REG_RIN] = 1'b1;
                    end
                    CL_ALU_R, CL_ALU_I: begin
                        reg_ctl_o[REG_GRB]  = 1'b1;
                        reg_ctl_o[REG_ROUT] = 1'b1;
                        load_o[LOAD_Y]      = 1'b1;
                    end
                    CL_MULDIV: begin
                        reg_ctl_o[REG_GRA]  = 1'b1;
                        reg_ctl_o[REG_ROUT] = 1'b1;
                        load_o[LOAD_Y]      = 1'b1;
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        reg_ctl_o[REG_GRB]   = 1'b1;
                        reg_ctl_o[REG_BAOUT] = 1'b1;
                        load_o[LOAD_Y]       = 1'b1;
                    end
                    CL_BR: begin
                        reg_ctl_o[REG_GRA]  = 1'b1;
                        reg_ctl_o[REG_ROUT] = 1'b1;
                    end
                    CL_IN: begin
                        drive_o[DRV_INPORT] = 1'b1;
                        reg_ctl_o[REG_GRA]  = 1'b1;
                        reg_ctl_o[REG_RIN]  = 1'b1;
                    end
                    CL_OUT: begin
                        reg_ctl_o[REG_GRA]   = 1'b1;
                        reg_ctl_o[REG_ROUT]  = 1'b1;
                        load_o[LOAD_OUTPORT] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                step_o = 3'd4;
                case (op_class_q)
                    CL_ALU_R: begin
                        reg_ctl_o[REG_GRC]  = 1'b1;
                        reg_ctl_o[REG_ROUT] = 1'b1;
                        alu_op_o            = opcode_q;
                        load_o[LOAD_Z]      = 1'b1;
                    end
                    CL_ALU_I: begin
                        drive_o[DRV_C]      = 1'b1;
                        alu_op_o            = opcode_q;
                        load_o[LOAD_Z]      = 1'b1;
                    end
                    CL_MULDIV: begin
                        reg_ctl_o[REG_GRB]  = 1'b1;
                        reg_ctl_o[REG_ROUT] = 1'b1;
                        alu_op_o            = opcode_q;
                        load_o[LOAD_Z]      = 1'b1;
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        drive_o[DRV_C]      = 1'b1;
                        alu_op_o            = ALU_ADD;
                        load_o[LOAD_Z]      = 1'b1;
                    end
                    CL_BR: begin
                        drive_o[DRV_PC]     = 1'b1;
                        load_o[LOAD_Y]      = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                step_o = 3'd5;
                case (op_class_q)
                    CL_ALU_R, CL_ALU_I, CL_LDI: begin
                        drive_o[DRV_ZLO]   = 1'b1;
                        reg_ctl_o[REG_GRA] = 1'b1;
                        reg_ctl_o[REG_RIN] = 1'b1;
                    end
                    CL_MULDIV: begin
                        drive_o[DRV_ZLO]   = 1'b1;
                        load_o[LOAD_LO]    = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        drive_o[DRV_ZLO]   = 1'b1;
                        load_o[LOAD_MAR]   = 1'b1;
                    end
                    CL_BR: begin
                        drive_o[DRV_C]     = 1'b1;
                        alu_op_o           = ALU_ADD;
                        load_o[LOAD_Z]     = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                step_o = 3'd6;
                case (op_class_q)
                    CL_MULDIV: begin
                        drive_o[DRV_ZHI]    = 1'b1;
                        load_o[LOAD_HI]     = 1'b1;
                    end
                    CL_LD: begin
                        mem_o[MEM_READ]     = 1'b1;
                        mem_o[MEM_EN]       = 1'b1;
                        load_o[LOAD_MDR]    = 1'b1;
                    end
                    CL_ST: begin
                        reg_ctl_o[REG_GRA]  = 1'b1;
                        reg_ctl_o[REG_ROUT] = 1'b1;
                        load_o[LOAD_MDR]    = 1'b1;
                    end
                    CL_BR: begin
                        drive_o[DRV_ZLO]    = 1'b1;
                        load_o[LOAD_PC]     = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                step_o = 3'd7;
                case (op_class_q)
                    CL_LD: begin
                        drive_o[DRV_MDR]   = 1'b1;
                        reg_ctl_o[REG_GRA] = 1'b1;
                        reg_ctl_o[REG_RIN] = 1'b1;
                    end
                    CL_ST: begin
                        mem_o[MEM_WRITE]   = 1'b1;
                        mem_o[MEM_EN]      = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT:  halted_o = 1'b1;
            default: ;
        endcase
    end

endmodule : control_sequencer
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_sequencer
//  Brief    : Directed self-checking bench for control_sequencer with
//             hand-computed control-word expectations per T-step.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    localparam int OPC_W      = 5;
    localparam int MULDIV_CYC = 32;
    localparam int CNT_W      = 6;

`ifdef CTRL_SEQ_MEMWAIT_EN
    localparam int LD_T6_CYC = 4;
`else
    localparam int LD_T6_CYC = 1;
`endif

    logic             Clock;
    logic             clear;
    logic             run;
    logic [OPC_W-1:0] ir_opcode;
    logic             con_ff_bit;
    logic             mem_ready;
    logic [7:0]       drive_o;
    logic [8:0]       load_o;
    logic [5:0]       reg_ctl_o;
    logic [OPC_W-1:0] alu_op_o;
    logic             incpc_o;
    logic [2:0]       mem_o;
    logic             halted_o;
    logic [2:0]       step_o;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int t0     = 0;
    int n      = 0;

    control_sequencer #(
        .OPC_W      (OPC_W),
        .MULDIV_CYC (MULDIV_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .Clock      (Clock),
        .clear      (clear),
        .run        (run),
        .ir_opcode  (ir_opcode),
        .con_ff_bit (con_ff_bit),
        .mem_ready  (mem_ready),
        .drive_o    (drive_o),
        .load_o     (load_o),
        .reg_ctl_o  (reg_ctl_o),
        .alu_op_o   (alu_op_o),
        .incpc_o    (incpc_o),
        .mem_o      (mem_o),
        .halted_o   (halted_o),
        .step_o     (step_o)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one clock and settle past the edge before sampling
    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    // Compare the full control word against a hand-computed expectation
    task automatic chk(input string tag, input logic [2:0] st, input logic [7:0] d,
                       input logic [8:0] l, input logic [5:0] r, input logic [4:0] a,
                       input logic inc, input logic [2:0] m, input logic h);
        logic [35:0] obs;
        logic [35:0] exp;
        obs = {step_o, drive_o, load_o, reg_ctl_o, alu_op_o, incpc_o, mem_o, halted_o};
        exp = {st, d, l, r, a, inc, m, h};
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%09h expected=%09h", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, 3'd0, 8'h00, 9'h000, 6'h00, 5'd0, 1'b0, 3'b000, 1'b0);
    endtask

    // Start an instruction from idle and check the three fetch steps; ends in T3
    task automatic fetch(input logic [4:0] op);
        ir_opcode = op;
        run = 1'b1;
        tick();
        t0 = cyc;
        chk("fetch_t0", 3'd0, 8'h10, 9'h003, 6'h00, 5'd3, 1'b1, 3'b000, 1'b0);
        run = 1'b0;
        tick();
        chk("fetch_t1", 3'd1, 8'h08, 9'h00C, 6'h00, 5'd0, 1'b0, 3'b101, 1'b0);
        tick();
        chk("fetch_t2", 3'd2, 8'h20, 9'h010, 6'h00, 5'd0, 1'b0, 3'b000, 1'b0);
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1; run = 1'b0; ir_opcode = '0; con_ff_bit = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        chk_idle("reset_state");
        clear = 1'b0;
        tick(); tick();
        chk_idle("run0_holds_idle");

        // mfhi: T0-T3 in four cycles, back to T0 on the fifth
        fetch(5'd24);
        chk("mfhi_t3", 3'd3, 8'h01, 9'h000, 6'h09, 5'd0, 1'b0, 3'b000, 1'b0);
        tick();
        chk_idle("mfhi_done");
        chk_val("mfhi_cycles", cyc - t0, 4);

        // add r1,r2,r3
        fetch(5'd3);
        chk("add_t3", 3'd3, 8'h00, 9'h020, 6'h12, 5'd0, 1'b0, 3'b000, 1'b0);
        tick();
        chk("add_t4", 3'd4, 8'h00, 9'h002, 6'h14, 5'd3, 1'b0, 3'b000, 1'b0);
        tick();
        chk("add_t5", 3'd5, 8'h08, 9'h000, 6'h09, 5'd0, 1'b0, 3'b000, 1'b0);
        tick();
        chk_idle("add_done");
        chk_val("add_cycles", cyc - t0, 6);

        // addi: T4 takes the constant instead of Rc
        fetch(5'd12);
        tick();
        chk("addi_t4", 3'd4, 8'h40, 9'h002, 6'h00, 5'd12, 1'b0, 3'b000, 1'b0);
        tick(); tick();
        chk_idle("addi_done");

        // mul: T4 held MULDIV_CYC cycles
        fetch(5'd15);
        chk("mul_t3", 3'd3, 8'h00, 9'h020, 6'h11, 5'd0, 1'b0, 3'b000, 1'b0);
        tick();
        chk("mul_t4", 3'd4, 8'h00, 9'h002, 6'h12, 5'd15, 1'b0, 3'b000, 1'b0);
        n = 0;
        while (step_o == 3'd4 && n < 100) begin
            n++;
            tick();
        end
        chk_val("mul_t4_len", n, MULDIV_CYC);
        chk("mul_t5", 3'd5, 8'h08, 9'h080, 6'h00, 5'd0, 1'b0, 3'b000, 1'b0);
        tick();
        chk("mul_t6", 3'd6, 8'h04, 9'h040, 6'h00, 5'd0, 1'b0, 3'b000, 1'b0);
        tick();
        chk_idle("mul_done");
        chk_val("mul_cycles", cyc - t0, 38);

        // br not taken
        con_ff_bit = 1'b0;
        fetch(5'd19);
        chk("br0_t3", 3'd3, 8'h00, 9'h000, 6'h11, 5'd0, 1'b0, 3'b000, 1'b0);
        tick();
        chk_idle("br0_done");

        // br taken
        con_ff_bit = 1'b1;
        fetch(5'd19);
        tick();
        chk("br1_t4", 3'd4, 8'h10, 9'h020, 6'h00, 5'd0, 1'b0, 3'b000, 1'b0);
        tick();
        chk("br1_t5", 3'd5, 8'h40, 9'h002, 6'h00, 5'd3, 1'b0, 3'b000, 1'b0);
        tick();
        chk("br1_t6", 3'd6, 8'h08, 9'h004, 6'h00, 5'd0, 1'b0, 3'b000, 1'b0);
        tick();
        chk_idle("br1_done");
        con_ff_bit = 1'b0;

        // ld with mem_ready low for the first three T6 cycles
        fetch(5'd0);
        chk("ld_t3", 3'd3, 8'h00, 9'h020, 6'h22, 5'd0, 1'b0, 3'b000, 1'b0);
        tick();
        chk("ld_t4", 3'd4, 8'h40, 9'h002, 6'h00, 5'd3, 1'b0, 3'b000, 1'b0);
        tick();
        chk("ld_t5", 3'd5, 8'h08, 9'h001, 6'h00, 5'd0, 1'b0, 3'b000, 1'b0);
        mem_ready = 1'b0;
        tick();
        chk("ld_t6", 3'd6, 8'h00, 9'h008, 6'h00, 5'd0, 1'b0, 3'b101, 1'b0);
        n = 1;
        while (step_o == 3'd6 && n < 20) begin
            if (n == 4) mem_ready = 1'b1;
            tick();
            if (step_o == 3'd6) begin
                n++;
                chk("ld_t6_held", 3'd6, 8'h00, 9'h008, 6'h00, 5'd0, 1'b0, 3'b101, 1'b0);
            end
        end
        mem_ready = 1'b1;
        chk_val("ld_t6_len", n, LD_T6_CYC);
        chk("ld_t7", 3'd7, 8'h20, 9'h000, 6'h09, 5'd0, 1'b0, 3'b000, 1'b0);
        tick();
        chk_idle("ld_done");

        // st
        fetch(5'd2);
        tick(); tick(); tick();
        chk("st_t6", 3'd6, 8'h00, 9'h008, 6'h11, 5'd0, 1'b0, 3'b000, 1'b0);
        tick();
        chk("st_t7", 3'd7, 8'h00, 9'h000, 6'h00, 5'd0, 1'b0, 3'b110, 1'b0);
        tick();
        chk_idle("st_done");

        // in / out / undefined opcode
        fetch(5'd22);
        chk("in_t3", 3'd3, 8'h80, 9'h000, 6'h09, 5'd0, 1'b0, 3'b000, 1'b0);
        tick();
        fetch(5'd23);
        chk("out_t3", 3'd3, 8'h00, 9'h100, 6'h11, 5'd0, 1'b0, 3'b000, 1'b0);
        tick();
        fetch(5'd7);
        chk("undef_t3", 3'd3, 8'h00, 9'h000, 6'h00, 5'd0, 1'b0, 3'b000, 1'b0);
        tick();
        chk_idle("undef_done");

        // clear in mul T4 when the stall counter reads 17
        fetch(5'd15);
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("mul_t4_mid", 3'd4, 8'h00, 9'h002, 6'h12, 5'd15, 1'b0, 3'b000, 1'b0);
        clear = 1'b1;
        tick();
        chk_idle("clear_mid_stall");
        clear = 1'b0;
        tick();
        chk_idle("clear_then_idle");

        // halt holds until clear, even with run=1
        fetch(5'd27);
        tick();
        chk("halt_1", 3'd0, 8'h00, 9'h000, 6'h00, 5'd0, 1'b0, 3'b000, 1'b1);
        run = 1'b1;
        tick(); tick();
        chk("halt_2", 3'd0, 8'h00, 9'h000, 6'h00, 5'd0, 1'b0, 3'b000, 1'b1);
        run = 1'b0;
        clear = 1'b1;
        tick();
        chk_idle("halt_cleared");
        clear = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_control_sequencer
`default_nettype wire
